serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 156 +++++++++++++++
 tb/tb_serial_subtractor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial a-b over 8/16/32/64-bit elements, one result bit
//               per clock, with valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int MAX_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAX_W-1:0] a,
    input  logic [MAX_W-1:0] b,
    input  logic [1:0]       sew,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAX_W-1:0] d,
    output logic             borrow,
    output logic             overflow
);

    localparam int c_CNT_W = $clog2(MAX_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [MAX_W-1:0]     r_a;
    logic [MAX_W-1:0]     r_b;
    logic [MAX_W-1:0]     r_acc;
    logic [MAX_W-1:0]     r_d;
    logic [1:0]           r_sew;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_carry;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_borrow;
    logic                 r_overflow;

    logic                 w_abit;
    logic                 w_nbit;
    logic                 w_sum;
    logic                 w_cout;
    logic                 w_last;
    logic                 w_ovf;
    logic [MAX_W-1:0]     w_acc_next;
    logic [MAX_W-1:0]     w_in_mask;

    function automatic logic [MAX_W-1:0] width_mask(input logic [1:0] s);
        logic [MAX_W-1:0] m;
        case (s)
            2'b00:   m = MAX_W'(64'h0000_0000_0000_00FF);
            2'b01:   m = MAX_W'(64'h0000_0000_0000_FFFF);
            2'b10:   m = MAX_W'(64'h0000_0000_FFFF_FFFF);
            default: m = MAX_W'(64'hFFFF_FFFF_FFFF_FFFF);
        endcase
        return m;
    endfunction

    function automatic logic [c_CNT_W-1:0] last_index(input logic [1:0] s);
        logic [c_CNT_W-1:0] idx;
        case (s)
            2'b00:   idx = c_CNT_W'(7);
            2'b01:   idx = c_CNT_W'(15);
            2'b10:   idx = c_CNT_W'(31);
            default: idx = c_CNT_W'(63);
        endcase
        return idx;
    endfunction

    // One full-adder slice: a + ~b + carry, carry seeded with 1 at acceptance.
    assign w_in_mask  = width_mask(sew);
    assign w_abit     = r_a[r_cnt];
    assign w_nbit     = ~r_b[r_cnt];
    assign w_sum      = w_abit ^ w_nbit ^ r_carry;
    assign w_cout     = (w_abit & w_nbit) | (w_abit & r_carry) | (w_nbit & r_carry);
    assign w_last     = (r_cnt == last_index(r_sew));
    assign w_acc_next = r_acc | ({{(MAX_W-1){1'b0}}, w_sum} << r_cnt);
    // Evaluated only on the sign bit: operands differ in sign and result sign flips.
    assign w_ovf      = (r_a[r_cnt] != r_b[r_cnt]) && (w_sum != r_a[r_cnt]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_d         <= '0;
            r_sew       <= 2'b00;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_borrow    <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a & w_in_mask;
                        r_b        <= b & w_in_mask;
                        r_sew      <= sew;
                        r_cnt      <= '0;
                        r_carry    <= 1'b1;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + c_CNT_W'(1);
                    if (w_last) begin
                        r_d         <= w_acc_next;
                        r_borrow    <= ~w_cout;
                        r_overflow  <= w_ovf;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // Returning to IDLE here means a same-edge request waits a cycle.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_borrow    <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_borrow    <= 1'b0;
                    r_overflow  <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign d         = r_d;
    assign borrow    = r_borrow;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench: directed vector table, handshake corner
//               sequences and randomized back-to-back traffic vs. a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  sew;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] d;
    logic        borrow;
    logic        overflow;

    int errors;
    int checks;
    int cyc;

    serial_subtractor #(.MAX_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sew       (sew),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .borrow    (borrow),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [1:0]  sew;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_d;
        logic        exp_bo;
        logic        exp_ov;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain unsigned/signed arithmetic at width N.
    task automatic ref_sub(input logic [1:0] s, input logic [63:0] ra, input logic [63:0] rb,
                           output logic [63:0] rd, output logic rbo, output logic rov);
        int n;
        logic [63:0] m;
        logic [64:0] ua, ub, ud;
        logic signed [66:0] sa, sb, sd, pw, hi, lo;
        n  = 8 << s;
        m  = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
        ua = {1'b0, ra & m};
        ub = {1'b0, rb & m};
        ud = ua - ub;
        rd = ud[63:0] & m;
        rbo = (ua < ub);
        pw = 67'sd1 <<< n;
        sa = $signed({2'b00, ua});
        sb = $signed({2'b00, ub});
        if (ua[n-1]) sa = sa - pw;
        if (ub[n-1]) sb = sb - pw;
        sd = sa - sb;
        hi = (67'sd1 <<< (n - 1)) - 67'sd1;
        lo = -(67'sd1 <<< (n - 1));
        rov = (sd > hi) || (sd < lo);
    endtask

    // Issues one operation and checks latency and result; optionally consumes it.
    task automatic do_op(input string nm, input logic [1:0] s, input logic [63:0] va,
                         input logic [63:0] vb, input logic [63:0] ed, input logic ebo,
                         input logic eov, input bit consume, output int acc_cyc);
        int t;
        int lat;
        int n;
        n = 8 << s;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        chk({nm, "_ready_wait"}, {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        sew = s;
        a = va;
        b = vb;
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        sew = 2'($urandom_range(0, 3));
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
        end
        chk({nm, "_latency"}, 64'(lat), 64'(n));
        chk({nm, "_d"}, d, ed);
        chk({nm, "_borrow"}, {63'd0, borrow}, {63'd0, ebo});
        chk({nm, "_overflow"}, {63'd0, overflow}, {63'd0, eov});
        if (consume) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk({nm, "_consumed_valid"}, {63'd0, out_valid}, 64'd0);
            chk({nm, "_consumed_ready"}, {63'd0, in_ready}, 64'd1);
        end
    endtask

    vec_t vecs[8];

    initial begin
        int acc;
        int prev_acc;
        int prev_n;
        logic [63:0] hold_d;
        logic [63:0] rd;
        logic rbo, rov;
        logic [1:0] rs;
        logic [63:0] ra, rb;

        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = 64'd0;
        b = 64'd0;
        sew = 2'b00;

        vecs[0] = '{2'b00, 64'h05, 64'h03, 64'h02, 1'b0, 1'b0};
        vecs[1] = '{2'b00, 64'h00, 64'h01, 64'hFF, 1'b1, 1'b0};
        vecs[2] = '{2'b00, 64'h80, 64'h01, 64'h7F, 1'b0, 1'b1};
        vecs[3] = '{2'b01, 64'hFFFF_0003, 64'h0000_0004, 64'h0000_0000_0000_FFFF, 1'b1, 1'b0};
        vecs[4] = '{2'b11, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0};
        vecs[5] = '{2'b10, 64'hDEAD_0000_8000_0000, 64'h1, 64'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[6] = '{2'b11, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[7] = '{2'b01, 64'h7FFF, 64'hFFFF, 64'h8000, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_d", d, 64'd0);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_borrow", {63'd0, borrow}, 64'd0);
        chk("reset_overflow", {63'd0, overflow}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].sew, vecs[i].a, vecs[i].b,
                  vecs[i].exp_d, vecs[i].exp_bo, vecs[i].exp_ov, 1'b1, acc);
        end

        // Stall in DONE with requests and operand churn.
        out_ready = 1'b0;
        do_op("hold", 2'b00, 64'h33, 64'h11, 64'h22, 1'b0, 1'b0, 1'b0, acc);
        hold_d = d;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            @(posedge clk); #1;
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_d", d, hold_d);
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", {63'd0, out_valid}, 64'd0);
        chk("release_no_accept", {63'd0, in_ready}, 64'd1);
        chk("release_d_kept", d, hold_d);
        in_valid = 1'b0;

        // Abort mid-run with reset.
        in_valid = 1'b1;
        sew = 2'b10;
        a = 64'h1234_5678;
        b = 64'h0000_1111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_d", d, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        do_op("after_abort", 2'b00, 64'h10, 64'h01, 64'h0F, 1'b0, 1'b0, 1'b1, acc);

        // Randomized back-to-back traffic.
        prev_acc = 0;
        prev_n = 0;
        for (int r = 0; r < 30; r++) begin
            rs = 2'($urandom_range(0, 3));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (r % 5 == 0) rb = ra;
            ref_sub(rs, ra, rb, rd, rbo, rov);
            do_op($sformatf("rand%0d", r), rs, ra, rb, rd, rbo, rov, 1'b1, acc);
            if (r > 0) chk("issue_interval", 64'(acc - prev_acc), 64'(prev_n + 2));
            prev_acc = acc;
            prev_n = 8 << rs;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
